regfile_driver: RTL

Synthesizable initiator for the regfile read/write port. It accepts queued operations in the five-field vector format (R_en, R_addr, W_en, W_addr, W_data) and issues one operation per cycle to the regfile. It returns read data with its address and folds every read result into a MISR signature. It sits beside the regfile in energy-characterization builds, so that on-silicon and gate-level runs replay the same operation streams without a testbench.

---
 rtl/regfile_driver_pkg.sv | 31 +++
 rtl/regfile_driver_fifo.sv | 55 +++++
 rtl/regfile_driver.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/regfile_driver_pkg.sv
// Shared types and constants for the regfile driver: FSM state encoding,
// operation field packing order and the default MISR polynomial.
package regfile_driver_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int DEF_WIDTH      = 32;
    localparam int DEF_N          = 32;
    localparam int DEF_ADDR_WIDTH = $clog2(DEF_N);

    localparam logic [31:0] DEFAULT_POLY = 32'h04C11DB7;

    // Field order matches one line of the operation vector files.
    typedef struct packed {
        logic                      r_en;
        logic [DEF_ADDR_WIDTH-1:0] r_addr;
        logic                      w_en;
        logic [DEF_ADDR_WIDTH-1:0] w_addr;
        logic [DEF_WIDTH-1:0]      w_data;
    } op_t;

    function automatic int op_bits(input int addr_width, input int width);
        return 2 + 2 * addr_width + width;
    endfunction

endpackage

// File: rtl/regfile_driver_fifo.sv
// Small synchronous operation queue; head entry is presented combinationally
// so a pop at edge k lands in the port registers at that same edge.
module regfile_driver_fifo
    import regfile_driver_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int OP_W  = op_bits(DEF_ADDR_WIDTH, DEF_WIDTH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  logic [OP_W-1:0] push_data,
    input  logic            pop,
    output logic [OP_W-1:0] pop_data,
    output logic            full,
    output logic            empty
);

    localparam int AW = $clog2(DEPTH);

    logic [OP_W-1:0] mem [DEPTH];
    logic [AW:0]     wr_ptr_reg;
    logic [AW:0]     rd_ptr_reg;
    logic            do_push;
    logic            do_pop;

    // Extra pointer bit distinguishes full from empty when indices match.
    assign full     = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                      (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign empty    = (wr_ptr_reg == rd_ptr_reg);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_driver.sv
// Replays queued read/write operations onto the regfile port, one per cycle,
// returns read results with their address and folds them into a MISR.
module regfile_driver
    import regfile_driver_pkg::*;
#(
    parameter int          WIDTH        = 32,
    parameter int          N            = 32,
    parameter int          DEPTH        = 4,
    parameter int          READ_LATENCY = 1,
    parameter logic [31:0] POLY         = DEFAULT_POLY,
    localparam int         ADDR_WIDTH   = $clog2(N)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  op_valid,
    output logic                  op_ready,
    input  logic                  op_r_en,
    input  logic [ADDR_WIDTH-1:0] op_r_addr,
    input  logic                  op_w_en,
    input  logic [ADDR_WIDTH-1:0] op_w_addr,
    input  logic [WIDTH-1:0]      op_w_data,
    input  logic                  start,
    input  logic [15:0]           num_ops,
    output logic                  busy,
    output logic                  done,
    output logic                  R_en,
    output logic [ADDR_WIDTH-1:0] R_addr,
    output logic                  W_en,
    output logic [ADDR_WIDTH-1:0] W_addr,
    output logic [WIDTH-1:0]      W_data,
    input  logic [WIDTH-1:0]      R_data,
    output logic                  rd_valid,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [WIDTH-1:0]      rd_data,
    output logic [WIDTH-1:0]      signature,
    output logic [15:0]           op_count
);

    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_RUN   = RUN;
    localparam logic [1:0] S_DRAIN = DRAIN;
    localparam logic [1:0] S_DONE  = DONE;

    localparam int              OP_W   = op_bits(ADDR_WIDTH, WIDTH);
    localparam logic [WIDTH-1:0] POLY_W = WIDTH'(POLY);

    typedef struct packed {
        logic                  r_en;
        logic [ADDR_WIDTH-1:0] r_addr;
        logic                  w_en;
        logic [ADDR_WIDTH-1:0] w_addr;
        logic [WIDTH-1:0]      w_data;
    } op_s;

    function automatic logic [WIDTH-1:0] misr_step(input logic [WIDTH-1:0] sig,
                                                   input logic [WIDTH-1:0] din);
        return {sig[WIDTH-2:0], 1'b0} ^ (sig[WIDTH-1] ? POLY_W : '0) ^ din;
    endfunction

    logic [1:0]  state_reg;
    logic [1:0]  state_next;
    logic [15:0] num_ops_reg;
    logic [15:0] op_count_reg;
    logic        fifo_full;
    logic        fifo_empty;
    logic        pop;
    logic        last_pop;
    logic        run_start;
    logic        read_inflight;
    op_s         op_in;
    op_s         op_head;

    logic                  pipe_v_reg    [READ_LATENCY];
    logic [ADDR_WIDTH-1:0] pipe_addr_reg [READ_LATENCY];
    logic                  rd_capture;

    assign op_in = {op_r_en, op_r_addr, op_w_en, op_w_addr, op_w_data};

    regfile_driver_fifo #(
        .DEPTH (DEPTH),
        .OP_W  (OP_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (op_valid),
        .push_data (op_in),
        .pop       (pop),
        .pop_data  (op_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign op_ready      = !fifo_full;
    assign pop           = (state_reg == S_RUN) && !fifo_empty;
    assign last_pop      = ((op_count_reg + 16'd1) == num_ops_reg);
    assign run_start     = (state_reg == S_IDLE) && start && (num_ops != 16'd0);
    assign rd_capture    = pipe_v_reg[READ_LATENCY-1];
    assign busy          = (state_reg == S_RUN) || (state_reg == S_DRAIN);
    assign done          = (state_reg == S_DONE);
    assign op_count      = op_count_reg;

    // Any read still travelling toward rd_valid keeps the FSM in DRAIN.
    always_comb begin
        read_inflight = R_en;
        for (int i = 0; i < READ_LATENCY; i++) begin
            read_inflight = read_inflight | pipe_v_reg[i];
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    state_next = (num_ops == 16'd0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (pop && last_pop) begin
                    state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!read_inflight) begin
                    state_next = S_DONE;
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= S_IDLE;
            num_ops_reg  <= '0;
            op_count_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (run_start) begin
                num_ops_reg  <= num_ops;
                op_count_reg <= '0;
            end else if (pop) begin
                op_count_reg <= op_count_reg + 16'd1;
            end
        end
    end

    // Addresses and write data only change on a pop so idle cycles do not toggle the bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            R_en   <= 1'b0;
            W_en   <= 1'b0;
            R_addr <= '0;
            W_addr <= '0;
            W_data <= '0;
        end else begin
            R_en <= pop ? op_head.r_en : 1'b0;
            W_en <= pop ? op_head.w_en : 1'b0;
            if (pop) begin
                R_addr <= op_head.r_addr;
                W_addr <= op_head.w_addr;
                W_data <= op_head.w_data;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < READ_LATENCY; gi++) begin : g_rd_pipe
            if (gi == 0) begin : g_first
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        pipe_v_reg[gi]    <= 1'b0;
                        pipe_addr_reg[gi] <= '0;
                    end else begin
                        pipe_v_reg[gi]    <= R_en;
                        pipe_addr_reg[gi] <= R_addr;
                    end
                end
            end else begin : g_rest
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        pipe_v_reg[gi]    <= 1'b0;
                        pipe_addr_reg[gi] <= '0;
                    end else begin
                        pipe_v_reg[gi]    <= pipe_v_reg[gi-1];
                        pipe_addr_reg[gi] <= pipe_addr_reg[gi-1];
                    end
                end
            end
        end
    endgenerate

    // Signature advances on the same edge that raises rd_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid  <= 1'b0;
            rd_addr   <= '0;
            rd_data   <= '0;
            signature <= '0;
        end else begin
            rd_valid <= rd_capture;
            if (rd_capture) begin
                rd_addr <= pipe_addr_reg[READ_LATENCY-1];
                rd_data <= R_data;
            end
            if (run_start) begin
                signature <= '0;
            end else if (rd_capture) begin
                signature <= misr_step(signature, R_data);
            end
        end
    end

endmodule
